// File: rtl/jtag_tap_regs.sv
// jtag_tap_regs: JTAG TAP instruction register plus BYPASS, IDCODE and USER data-register chains
module jtag_tap_regs #(
  parameter int                    IR_WIDTH   = 4,
  parameter logic [31:0]           IDCODE_VAL = 32'h1000_0001,
  parameter int                    USER_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0]   OP_IDCODE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]   OP_USER    = IR_WIDTH'(2)
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TDI,
  input  logic                  state_TLR,
  input  logic                  state_CIR,
  input  logic                  state_SIR,
  input  logic                  state_UIR,
  input  logic                  state_CDR,
  input  logic                  state_SDR,
  input  logic                  state_UDR,
  output logic                  TDO,
  output logic                  TDO_EN,
  output logic [IR_WIDTH-1:0]   ir_out,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_dr_update
);
  logic [IR_WIDTH-1:0]   ir, ir_sh;
  logic                  bypass;
  logic [31:0]           idc_sh;
  logic [USER_WIDTH-1:0] usr_sh;
  logic                  sel_idc, sel_usr, sel_byp;
  assign sel_idc = (ir == OP_IDCODE);
  assign sel_usr = (ir == OP_USER);
  assign sel_byp = !sel_idc && !sel_usr;
  assign ir_out  = ir;
  assign TDO_EN  = state_SIR | state_SDR;
  always_comb
    TDO = state_SIR ? ir_sh[0] :
          state_SDR ? (sel_idc ? idc_sh[0] : sel_usr ? usr_sh[0] : bypass) : 1'b0;
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir             <= OP_IDCODE;
      ir_sh          <= '0;
      bypass         <= 1'b0;
      idc_sh         <= '0;
      usr_sh         <= '0;
      user_dr_out    <= '0;
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
      if (state_TLR) ir <= OP_IDCODE;
      if (state_CIR) ir_sh <= IR_WIDTH'(1);
      if (state_SIR) ir_sh <= {TDI, ir_sh[IR_WIDTH-1:1]};
      if (state_UIR) ir <= ir_sh;
      if (state_CDR) begin
        if (sel_byp) bypass <= 1'b0;
        if (sel_idc) idc_sh <= IDCODE_VAL;
        if (sel_usr) usr_sh <= user_dr_in;
      end
      // shift form keeps a one-bit USER register legal
      if (state_SDR) begin
        if (sel_byp) bypass <= TDI;
        if (sel_idc) idc_sh <= {TDI, idc_sh[31:1]};
        if (sel_usr) usr_sh <= (usr_sh >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH - 1));
      end
      if (state_UDR && sel_usr) begin
        user_dr_out    <= usr_sh;
        user_dr_update <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtag_tap_regs.sv
// tb_jtag_tap_regs: directed-vector self-checking bench for jtag_tap_regs
module tb_jtag_tap_regs;
  localparam logic [6:0] S_IDLE = 7'b0000000;
  localparam logic [6:0] S_TLR  = 7'b1000000;
  localparam logic [6:0] S_CIR  = 7'b0100000;
  localparam logic [6:0] S_SIR  = 7'b0010000;
  localparam logic [6:0] S_UIR  = 7'b0001000;
  localparam logic [6:0] S_CDR  = 7'b0000100;
  localparam logic [6:0] S_SDR  = 7'b0000010;
  localparam logic [6:0] S_UDR  = 7'b0000001;
  logic       TCK = 1'b0, TRST = 1'b1, TDI = 1'b0;
  logic [6:0] st = S_IDLE;
  logic       TDO, TDO_EN, user_dr_update;
  logic [3:0] ir_out;
  logic [7:0] user_dr_in = 8'h00, user_dr_out;
  int checks = 0, failures = 0;
  jtag_tap_regs dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI),
    .state_TLR(st[6]), .state_CIR(st[5]), .state_SIR(st[4]), .state_UIR(st[3]),
    .state_CDR(st[2]), .state_SDR(st[1]), .state_UDR(st[0]),
    .TDO(TDO), .TDO_EN(TDO_EN), .ir_out(ir_out),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_dr_update(user_dr_update)
  );
  always #5 TCK = ~TCK;
  always @(posedge TCK) assert ($onehot0(st)) else $error("state flags not one-hot: %b", st);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [6:0] s, input logic d, input logic r, output logic o);
    st = s; TDI = d; TRST = r;
    #1 o = TDO;
    @(posedge TCK);
    #1;
  endtask
  task automatic load_ir(input logic [3:0] v, output logic [3:0] out);
    logic o;
    cyc(S_CIR, 1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) begin
      cyc(S_SIR, v[i], 1'b0, o);
      out[i] = o;
    end
    cyc(S_UIR, 1'b0, 1'b0, o);
  endtask
  initial begin
    logic        o;
    logic [31:0] w;
    logic [3:0]  iro;
    logic [4:0]  bw;
    logic [2:0]  b3;
    logic [7:0]  uw;
    logic [4:0]  byp_tdi;
    logic [7:0]  usr_tdi;
    byp_tdi = 5'b01101;
    usr_tdi = 8'hA5;
    cyc(S_IDLE, 1'b0, 1'b1, o);
    cyc(S_IDLE, 1'b0, 1'b1, o);
    check("rst_ir", ir_out, 4'b0001);
    check("rst_user", user_dr_out, 8'h00);
    check("rst_upd", user_dr_update, 1'b0);
    check("rst_tdo", TDO, 1'b0);
    check("rst_tdo_en", TDO_EN, 1'b0);
    cyc(S_CDR, 1'b0, 1'b0, o);
    w = '0;
    for (int i = 0; i < 32; i++) begin
      cyc(S_SDR, 1'b0, 1'b0, o);
      w[i] = o;
    end
    check("idcode_stream", w, 32'h1000_0001);
    check("idcode_ir", ir_out, 4'b0001);
    load_ir(4'b1111, iro);
    check("ir_capture_stream", iro, 4'b0001);
    check("ir_after_uir", ir_out, 4'b1111);
    cyc(S_CDR, 1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      cyc(S_SDR, byp_tdi[i], 1'b0, o);
      bw[i] = o;
    end
    check("bypass_stream", bw, 5'b11010);
    load_ir(4'b0010, iro);
    check("ir_user", ir_out, 4'b0010);
    user_dr_in = 8'h3C;
    cyc(S_CDR, 1'b0, 1'b0, o);
    for (int i = 0; i < 8; i++) begin
      cyc(S_SDR, usr_tdi[i], 1'b0, o);
      uw[i] = o;
    end
    check("user_stream", uw, 8'h3C);
    check("user_pre_udr", user_dr_out, 8'h00);
    check("upd_pre_udr", user_dr_update, 1'b0);
    cyc(S_UDR, 1'b0, 1'b0, o);
    check("user_out", user_dr_out, 8'hA5);
    check("upd_pulse", user_dr_update, 1'b1);
    cyc(S_IDLE, 1'b0, 1'b0, o);
    check("upd_clear", user_dr_update, 1'b0);
    check("user_hold", user_dr_out, 8'hA5);
    load_ir(4'b0111, iro);
    check("ir_undef", ir_out, 4'b0111);
    cyc(S_CDR, 1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) begin
      cyc(S_SDR, (i < 2) ? 1'b1 : 1'b0, 1'b0, o);
      b3[i] = o;
    end
    check("undef_bypass_stream", b3, 3'b110);
    cyc(S_UDR, 1'b0, 1'b0, o);
    check("undef_udr_user", user_dr_out, 8'hA5);
    check("undef_udr_upd", user_dr_update, 1'b0);
    cyc(S_TLR, 1'b0, 1'b0, o);
    check("tlr_ir", ir_out, 4'b0001);
    check("tlr_user_hold", user_dr_out, 8'hA5);
    cyc(S_CIR, 1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) cyc(S_SIR, 1'b1, 1'b0, o);
    cyc(S_SIR, 1'b1, 1'b1, o);
    check("sir_pre_trst_tdo", o, 1'b1);
    st = S_SIR; TRST = 1'b0;
    #1 check("sir_post_trst_tdo", TDO, 1'b0);
    check("trst_sir_ir", ir_out, 4'b0001);
    check("trst_user", user_dr_out, 8'h00);
    cyc(S_CDR, 1'b0, 1'b0, o);
    cyc(S_SDR, 1'b0, 1'b1, o);
    check("sdr_pre_trst_tdo", o, 1'b1);
    st = S_SDR; TRST = 1'b0;
    #1 check("sdr_post_trst_tdo", TDO, 1'b0);
    check("sdr_tdo_en", TDO_EN, 1'b1);
    check("trst_sdr_ir", ir_out, 4'b0001);
    st = S_IDLE;
    @(posedge TCK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
